btb_assoc: RTL and testbench

Parametrised two-way set-associative branch target buffer with per-entry saturating direction counters. It serves the fetch stage of the LC-3b pipeline. It answers a combinational lookup on the current fetch PC and returns hit, predicted direction and predicted target. It is trained by the write-back stage on every resolved conditional branch. It replaces the single-bit direct-mapped BTB with N-bit hysteresis, LRU replacement, a flush port and an update-suppress port for cache-miss stalls.

---
 rtl/btb_assoc_pkg.sv | 15 +
 rtl/btb_assoc_sat_counter.sv | 26 ++
 rtl/btb_assoc.sv | 144 ++++++++++++++
 tb/tb_btb_assoc.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/btb_assoc_pkg.sv
// Shared types and constants for the LC-3b two-way branch target buffer.
package btb_assoc_pkg;

    localparam int unsigned PC_W = 16;

    // Write-back compares its opcode against this to form upd_valid.
    localparam logic [3:0] LC3B_OP_BR = 4'b0000;

    // Tag and counter widths depend on module parameters, so they live in separate arrays.
    typedef struct packed {
        logic            valid;
        logic [PC_W-1:0] target;
    } btb_entry_t;

endpackage

// File: rtl/btb_assoc_sat_counter.sv
// Saturating direction counter next-value logic used on the update read-modify-write path.
module btb_sat_counter #(
    parameter int unsigned CTR_BITS = 2
) (
    input  logic [CTR_BITS-1:0] ctr_i,
    input  logic                inc,
    input  logic                dec,
    input  logic                load,
    output logic [CTR_BITS-1:0] ctr_c
);

    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(1) << (CTR_BITS - 1);

    always_comb begin
        ctr_c = ctr_i;
        if (load) begin
            ctr_c = CTR_INIT;
        end else if (inc && (ctr_i != CTR_MAX)) begin
            ctr_c = ctr_i + CTR_BITS'(1);
        end else if (dec && (ctr_i != '0)) begin
            ctr_c = ctr_i - CTR_BITS'(1);
        end
    end

endmodule

// File: rtl/btb_assoc.sv
// Two-way set-associative BTB with saturating direction counters and per-set LRU.
module btb_assoc
    import btb_assoc_pkg::*;
#(
    parameter int unsigned SETS     = 8,
    parameter int unsigned CTR_BITS = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] curr_pc,
    output logic        hit,
    output logic        predict_taken,
    output logic [15:0] predicted_pc,
    input  logic        upd_valid,
    input  logic        upd_stall,
    input  logic [15:0] upd_pc,
    input  logic [15:0] upd_target,
    input  logic        upd_taken,
    input  logic        flush
);

    localparam int unsigned IDX_BITS = $clog2(SETS);
    localparam int unsigned TAG_BITS = PC_W - 1 - IDX_BITS;

    btb_entry_t            entry_q [2][SETS];
    btb_entry_t            entry_d [2][SETS];
    logic [TAG_BITS-1:0]   tag_q   [2][SETS];
    logic [TAG_BITS-1:0]   tag_d   [2][SETS];
    logic [CTR_BITS-1:0]   ctr_q   [2][SETS];
    logic [CTR_BITS-1:0]   ctr_d   [2][SETS];
    logic [SETS-1:0]       lru_q;
    logic [SETS-1:0]       lru_d;

    logic [IDX_BITS-1:0]   l_idx;
    logic [TAG_BITS-1:0]   l_tag;
    logic [1:0]            l_match;
    logic [IDX_BITS-1:0]   u_idx;
    logic [TAG_BITS-1:0]   u_tag;
    logic [1:0]            u_match;
    logic                  u_hit;
    logic                  victim;
    logic                  sel_way;
    logic [CTR_BITS-1:0]   ctr_nxt;
    logic                  unused_pc_lsb;

    // Instructions are word aligned; bit 0 never participates.
    assign unused_pc_lsb = curr_pc[0] ^ upd_pc[0];

    assign l_idx = curr_pc[IDX_BITS:1];
    assign l_tag = curr_pc[PC_W-1:IDX_BITS+1];
    assign u_idx = upd_pc[IDX_BITS:1];
    assign u_tag = upd_pc[PC_W-1:IDX_BITS+1];

    always_comb begin
        for (int unsigned w = 0; w < 2; w++) begin
            l_match[w] = entry_q[w][l_idx].valid && (tag_q[w][l_idx] == l_tag);
            u_match[w] = entry_q[w][u_idx].valid && (tag_q[w][u_idx] == u_tag);
        end
    end

    // Lookup reads registered state only, giving read-before-write on a same-cycle update.
    always_comb begin
        hit           = 1'b0;
        predict_taken = 1'b0;
        predicted_pc  = '0;
        if (l_match[0]) begin
            hit           = 1'b1;
            predict_taken = ctr_q[0][l_idx][CTR_BITS-1];
            predicted_pc  = entry_q[0][l_idx].target;
        end else if (l_match[1]) begin
            hit           = 1'b1;
            predict_taken = ctr_q[1][l_idx][CTR_BITS-1];
            predicted_pc  = entry_q[1][l_idx].target;
        end
    end

    assign u_hit = |u_match;

    always_comb begin
        if (!entry_q[0][u_idx].valid) begin
            victim = 1'b0;
        end else if (!entry_q[1][u_idx].valid) begin
            victim = 1'b1;
        end else begin
            victim = lru_q[u_idx];
        end
    end

    // Allocation only happens on a miss, so u_match[1] alone names the hit way.
    assign sel_way = u_hit ? u_match[1] : victim;

    btb_sat_counter #(
        .CTR_BITS (CTR_BITS)
    ) u_ctr (
        .ctr_i (ctr_q[sel_way][u_idx]),
        .inc   (u_hit & upd_taken),
        .dec   (u_hit & ~upd_taken),
        .load  (~u_hit),
        .ctr_c (ctr_nxt)
    );

    always_comb begin
        entry_d = entry_q;
        tag_d   = tag_q;
        ctr_d   = ctr_q;
        lru_d   = lru_q;
        if (flush) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                entry_d[0][s].valid = 1'b0;
                entry_d[1][s].valid = 1'b0;
            end
            lru_d = '0;
        end else if (upd_valid && !upd_stall && (u_hit || upd_taken)) begin
            ctr_d[sel_way][u_idx] = ctr_nxt;
            lru_d[u_idx]          = ~sel_way;
            if (upd_taken) begin
                entry_d[sel_way][u_idx].target = upd_target;
            end
            if (!u_hit) begin
                entry_d[sel_way][u_idx].valid = 1'b1;
                tag_d[sel_way][u_idx]         = u_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                for (int unsigned w = 0; w < 2; w++) begin
                    entry_q[w][s] <= '0;
                    tag_q[w][s]   <= '0;
                    ctr_q[w][s]   <= '0;
                end
            end
            lru_q <= '0;
        end else begin
            entry_q <= entry_d;
            tag_q   <= tag_d;
            ctr_q   <= ctr_d;
            lru_q   <= lru_d;
        end
    end

endmodule

// File: tb/tb_btb_assoc.sv
// Self-checking bench: directed vector table on the default BTB plus a random scoreboard across three parameter sets.
module tb_btb_assoc;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [15:0] curr_pc;
    logic        upd_valid;
    logic        upd_stall;
    logic [15:0] upd_pc;
    logic [15:0] upd_target;
    logic        upd_taken;
    logic        h   [3];
    logic        pt  [3];
    logic [15:0] ppc [3];

    always #5 clk = ~clk;

    btb_assoc #(.SETS(8), .CTR_BITS(2)) u_dut0 (
        .clk(clk), .reset(reset), .curr_pc(curr_pc), .hit(h[0]), .predict_taken(pt[0]),
        .predicted_pc(ppc[0]), .upd_valid(upd_valid), .upd_stall(upd_stall), .upd_pc(upd_pc),
        .upd_target(upd_target), .upd_taken(upd_taken), .flush(flush)
    );
    btb_assoc #(.SETS(2), .CTR_BITS(1)) u_dut1 (
        .clk(clk), .reset(reset), .curr_pc(curr_pc), .hit(h[1]), .predict_taken(pt[1]),
        .predicted_pc(ppc[1]), .upd_valid(upd_valid), .upd_stall(upd_stall), .upd_pc(upd_pc),
        .upd_target(upd_target), .upd_taken(upd_taken), .flush(flush)
    );
    btb_assoc #(.SETS(64), .CTR_BITS(3)) u_dut2 (
        .clk(clk), .reset(reset), .curr_pc(curr_pc), .hit(h[2]), .predict_taken(pt[2]),
        .predicted_pc(ppc[2]), .upd_valid(upd_valid), .upd_stall(upd_stall), .upd_pc(upd_pc),
        .upd_target(upd_target), .upd_taken(upd_taken), .flush(flush)
    );

    typedef struct {
        string       name;
        logic        rst, fl, uv, us, ut;
        logic [15:0] upc, utgt, cpc;
        logic        eh, ept;
        logic [15:0] eppc;
    } vec_t;

    typedef struct {
        string       name;
        int          inst;
        logic        eh, ept;
        logic [15:0] eppc;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Behavioural reference for the random phase, one copy per instance.
    int p_sets [3] = '{8, 2, 64};
    int p_ib   [3] = '{3, 1, 6};
    int p_cb   [3] = '{2, 1, 3};
    bit m_valid [3][2][256];
    int m_tag   [3][2][256];
    int m_tgt   [3][2][256];
    int m_ctr   [3][2][256];
    int m_lru   [3][256];

    function automatic vec_t mk(input string n, input logic rst, fl, uv, us, ut,
                                input logic [15:0] upc, utgt, cpc,
                                input logic eh, ept, input logic [15:0] eppc);
        vec_t v;
        v.name = n; v.rst = rst; v.fl = fl; v.uv = uv; v.us = us; v.ut = ut;
        v.upc = upc; v.utgt = utgt; v.cpc = cpc; v.eh = eh; v.ept = ept; v.eppc = eppc;
        return v;
    endfunction

    task automatic check_outputs();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_tests++;
            if ({h[e.inst], pt[e.inst], ppc[e.inst]} !== {e.eh, e.ept, e.eppc}) begin
                n_fail++;
                $display("FAIL %s inst%0d pc=%h: got hit=%0b taken=%0b target=%h, want hit=%0b taken=%0b target=%h",
                         e.name, e.inst, curr_pc, h[e.inst], pt[e.inst], ppc[e.inst], e.eh, e.ept, e.eppc);
            end
        end
    endtask

    function automatic void m_clear(input int i, input bit full);
        for (int s = 0; s < 256; s++) begin
            m_lru[i][s] = 0;
            for (int w = 0; w < 2; w++) begin
                m_valid[i][w][s] = 1'b0;
                if (full) begin
                    m_tgt[i][w][s] = 0;
                    m_ctr[i][w][s] = 0;
                end
            end
        end
    endfunction

    function automatic exp_t m_lookup(input int i, input logic [15:0] pc);
        exp_t e;
        int   idx = (int'(pc) >> 1) & (p_sets[i] - 1);
        int   tag = int'(pc) >> (p_ib[i] + 1);
        e.name = "random";
        e.inst = i;
        e.eh   = 1'b0;
        e.ept  = 1'b0;
        e.eppc = 16'h0000;
        for (int w = 1; w >= 0; w--) begin
            if (m_valid[i][w][idx] && m_tag[i][w][idx] == tag) begin
                e.eh   = 1'b1;
                e.ept  = 1'((m_ctr[i][w][idx] >> (p_cb[i] - 1)) & 1);
                e.eppc = 16'(m_tgt[i][w][idx]);
            end
        end
        return e;
    endfunction

    function automatic void m_update(input int i);
        int idx = (int'(upd_pc) >> 1) & (p_sets[i] - 1);
        int tag = int'(upd_pc) >> (p_ib[i] + 1);
        int mx  = (1 << p_cb[i]) - 1;
        int w   = -1;
        int v;
        if (reset) begin
            m_clear(i, 1'b1);
        end else if (flush) begin
            m_clear(i, 1'b0);
        end else if (upd_valid && !upd_stall) begin
            for (int k = 0; k < 2; k++)
                if (m_valid[i][k][idx] && m_tag[i][k][idx] == tag) w = k;
            if (w >= 0) begin
                if (upd_taken) begin
                    if (m_ctr[i][w][idx] < mx) m_ctr[i][w][idx]++;
                    m_tgt[i][w][idx] = int'(upd_target);
                end else if (m_ctr[i][w][idx] > 0) begin
                    m_ctr[i][w][idx]--;
                end
                m_lru[i][idx] = 1 - w;
            end else if (upd_taken) begin
                v = !m_valid[i][0][idx] ? 0 : (!m_valid[i][1][idx] ? 1 : m_lru[i][idx]);
                m_valid[i][v][idx] = 1'b1;
                m_tag[i][v][idx]   = tag;
                m_tgt[i][v][idx]   = int'(upd_target);
                m_ctr[i][v][idx]   = 1 << (p_cb[i] - 1);
                m_lru[i][idx]      = 1 - v;
            end
        end
    endfunction

    function automatic logic [15:0] rand_pc();
        return 16'h3000 | (16'($urandom_range(0, 3)) << 8) | (16'($urandom_range(0, 15)) << 1);
    endfunction

    initial begin
        reset = 1'b1; flush = 1'b0; curr_pc = '0; upd_valid = 1'b0; upd_stall = 1'b0;
        upd_pc = '0; upd_target = '0; upd_taken = 1'b0;

        // name, rst, fl, uv, us, ut, upd_pc, upd_target, curr_pc, exp hit, exp taken, exp target
        vecs.push_back(mk("reset_3000",   1,0,0,0,0, 16'h0000,16'h0000,16'h3000, 0,0,16'h0000));
        vecs.push_back(mk("reset_0000",   0,0,0,0,0, 16'h0000,16'h0000,16'h0000, 0,0,16'h0000));
        vecs.push_back(mk("reset_fffe",   0,0,0,0,0, 16'h0000,16'h0000,16'hFFFE, 0,0,16'h0000));
        vecs.push_back(mk("nt_no_alloc",  0,0,1,0,0, 16'h3000,16'h3050,16'h3000, 0,0,16'h0000));
        vecs.push_back(mk("alloc_same",   0,0,1,0,1, 16'h3000,16'h3050,16'h3000, 0,0,16'h0000));
        vecs.push_back(mk("alloc_vis",    0,0,1,0,1, 16'h3000,16'h3050,16'h3000, 1,1,16'h3050));
        vecs.push_back(mk("sat_a",        0,0,1,0,1, 16'h3000,16'h3050,16'h3000, 1,1,16'h3050));
        vecs.push_back(mk("sat_b",        0,0,1,0,1, 16'h3000,16'h3050,16'h3000, 1,1,16'h3050));
        vecs.push_back(mk("nt_first",     0,0,1,0,0, 16'h3000,16'h3050,16'h3000, 1,1,16'h3050));
        vecs.push_back(mk("nt_hyst",      0,0,1,0,0, 16'h3000,16'h3050,16'h3000, 1,1,16'h3050));
        vecs.push_back(mk("nt_flip",      0,0,1,0,1, 16'h3000,16'h3060,16'h3000, 1,0,16'h3050));
        vecs.push_back(mk("tgt_update",   0,0,1,0,1, 16'h3010,16'h3110,16'h3000, 1,1,16'h3060));
        vecs.push_back(mk("way1_hit",     0,0,1,0,0, 16'h3000,16'h0000,16'h3010, 1,1,16'h3110));
        vecs.push_back(mk("lru_pre",      0,0,1,0,1, 16'h3020,16'h3220,16'h3000, 1,0,16'h3060));
        vecs.push_back(mk("lru_evicted",  0,0,0,0,0, 16'h0000,16'h0000,16'h3010, 0,0,16'h0000));
        vecs.push_back(mk("lru_kept",     0,0,0,0,0, 16'h0000,16'h0000,16'h3000, 1,0,16'h3060));
        vecs.push_back(mk("lru_new",      0,0,0,0,0, 16'h0000,16'h0000,16'h3020, 1,1,16'h3220));
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk("stall_hold", 0,0,1,1,1, 16'h3100,16'h3333,16'h3100, 0,0,16'h0000));
        vecs.push_back(mk("stall_after",  0,0,0,0,0, 16'h0000,16'h0000,16'h3100, 0,0,16'h0000));
        vecs.push_back(mk("stall_keep",   0,0,0,0,0, 16'h0000,16'h0000,16'h3000, 1,0,16'h3060));
        vecs.push_back(mk("flush_upd",    0,1,1,0,1, 16'h3040,16'h3440,16'h3000, 1,0,16'h3060));
        vecs.push_back(mk("flush_3000",   0,0,0,0,0, 16'h0000,16'h0000,16'h3000, 0,0,16'h0000));
        vecs.push_back(mk("flush_3020",   0,0,0,0,0, 16'h0000,16'h0000,16'h3020, 0,0,16'h0000));
        vecs.push_back(mk("flush_lost",   0,1,1,0,1, 16'h3040,16'h3440,16'h3040, 0,0,16'h0000));
        vecs.push_back(mk("flush_hold",   0,1,1,0,1, 16'h3040,16'h3440,16'h3040, 0,0,16'h0000));
        vecs.push_back(mk("post_flush",   0,0,1,0,1, 16'h3040,16'h3440,16'h3040, 0,0,16'h0000));
        vecs.push_back(mk("reset_upd",    1,0,1,0,1, 16'h3040,16'h3444,16'h3040, 1,1,16'h3440));
        vecs.push_back(mk("post_reset",   0,0,0,0,0, 16'h0000,16'h0000,16'h3040, 0,0,16'h0000));

        @(posedge clk); #1;
        foreach (vecs[n]) begin
            reset = vecs[n].rst; flush = vecs[n].fl; upd_valid = vecs[n].uv; upd_stall = vecs[n].us;
            upd_taken = vecs[n].ut; upd_pc = vecs[n].upc; upd_target = vecs[n].utgt; curr_pc = vecs[n].cpc;
            sb.push_back('{vecs[n].name, 0, vecs[n].eh, vecs[n].ept, vecs[n].eppc});
            #2 check_outputs();
            @(posedge clk); #1;
        end

        // Random streams against the reference model on all three parameter sets.
        reset = 1'b1; flush = 1'b0; upd_valid = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) m_clear(i, 1'b1);
        for (int c = 0; c < 600; c++) begin
            reset      = ($urandom_range(0, 99) < 2);
            flush      = ($urandom_range(0, 99) < 3);
            upd_valid  = ($urandom_range(0, 99) < 65);
            upd_stall  = ($urandom_range(0, 99) < 15);
            upd_taken  = ($urandom_range(0, 99) < 60);
            upd_pc     = rand_pc();
            upd_target = 16'($urandom) & 16'hFFFE;
            curr_pc    = ($urandom_range(0, 2) == 0) ? upd_pc : rand_pc();
            for (int i = 0; i < 3; i++) sb.push_back(m_lookup(i, curr_pc));
            #2 check_outputs();
            @(posedge clk);
            for (int i = 0; i < 3; i++) m_update(i);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
